multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: sequences IF/ID/EXE/MEM/WB per opcode
// and decodes datapath enables/selects from state and opcode.
// Ports: CLK, RST (async active-low), opcode[5:0], Zero in;
//   PCWre, IRWre, InsMemRW, RegWre, ExtSel, ALUSrcA, ALUSrcB, WrRegDSrc,
//   ALUM2Reg, RD/WR (active-low), RegDst[1:0], PCSrc[1:0], ALUCtrl[2:0],
//   state[2:0] (debug) out.
// Macro MULTICYCLE_CTRL_JAL_EN: when defined, jal links $31 and jumps in ID;
//   otherwise jal decodes as an undefined opcode (NOP).
module multicycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       Zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       ExtSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       WrRegDSrc,
  output logic       ALUM2Reg,
  output logic       RD,
  output logic       WR,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_M = 3'b010,
    S_MEM   = 3'b011,
    S_WB_L  = 3'b100,
    S_EXE_B = 3'b101,
    S_EXE_A = 3'b110,
    S_WB_A  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;

  state_t r_state;
  logic   r_halted;

  logic w_add, w_sub, w_addi, w_or, w_and, w_ori, w_slt;
  logic w_sw, w_lw, w_beq, w_j, w_jal, w_halt;
  logic w_r_type, w_i_type, w_alu, w_mem;
  logic [2:0] w_alu_ctrl;
  state_t w_id_next;

  assign w_add  = (opcode == OP_ADD);
  assign w_sub  = (opcode == OP_SUB);
  assign w_addi = (opcode == OP_ADDI);
  assign w_or   = (opcode == OP_OR);
  assign w_and  = (opcode == OP_AND);
  assign w_ori  = (opcode == OP_ORI);
  assign w_slt  = (opcode == OP_SLT);
  assign w_sw   = (opcode == OP_SW);
  assign w_lw   = (opcode == OP_LW);
  assign w_beq  = (opcode == OP_BEQ);
  assign w_j    = (opcode == OP_J);
  assign w_halt = (opcode == HALT_OP);

`ifdef MULTICYCLE_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL = 6'b111010;
  assign w_jal = (opcode == OP_JAL);
`else
  assign w_jal = 1'b0;
`endif

  assign w_r_type = w_add | w_sub | w_or | w_and | w_slt;
  assign w_i_type = w_addi | w_ori;
  assign w_alu    = w_r_type | w_i_type;
  assign w_mem    = w_lw | w_sw;

  always_comb begin
    w_alu_ctrl = 3'b000;
    unique case (1'b1)
      w_sub, w_beq: w_alu_ctrl = 3'b001;
      w_or, w_ori:  w_alu_ctrl = 3'b011;
      w_and:        w_alu_ctrl = 3'b100;
      w_slt:        w_alu_ctrl = 3'b110;
      default:      w_alu_ctrl = 3'b000;
    endcase
  end

  // j, jal and undefined opcodes all finish in ID and return to fetch.
  always_comb begin
    w_id_next = S_IF;
    unique case (1'b1)
      w_alu:   w_id_next = S_EXE_A;
      w_beq:   w_id_next = S_EXE_B;
      w_mem:   w_id_next = S_EXE_M;
      default: w_id_next = S_IF;
    endcase
  end

  // Halt parks the machine in IF; only reset clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      unique case (r_state)
        S_IF:    r_state <= S_ID;
        S_ID: begin
          if (w_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_IF;
          end else begin
            r_state  <= w_id_next;
          end
        end
        S_EXE_A: r_state <= S_WB_A;
        S_EXE_M: r_state <= S_MEM;
        S_MEM:   r_state <= w_lw ? S_WB_L : S_IF;
        S_EXE_B: r_state <= S_IF;
        S_WB_A:  r_state <= S_IF;
        S_WB_L:  r_state <= S_IF;
        default: r_state <= S_IF;
      endcase
    end
  end

  assign state = r_state;

  // Decode is gated by RST so a mid-instruction reset drops every
  // enable (including a pending memory write) without waiting for a clock.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    WrRegDSrc = 1'b0;
    ALUM2Reg  = 1'b0;
    RD        = 1'b1;
    WR        = 1'b1;
    RegDst    = 2'b00;
    PCSrc     = 2'b00;
    ALUCtrl   = 3'b000;
    if (RST && !r_halted) begin
      unique case (r_state)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          if (!w_halt) begin
            if (w_j) begin
              PCWre = 1'b1;
              PCSrc = 2'b11;
            end else if (w_jal) begin
              RegWre    = 1'b1;
              RegDst    = 2'b00;
              WrRegDSrc = 1'b0;
              PCWre     = 1'b1;
              PCSrc     = 2'b11;
            end else if (!(w_alu | w_beq | w_mem)) begin
              PCWre = 1'b1;
              PCSrc = 2'b00;
            end
          end
        end
        S_EXE_A: begin
          ALUSrcB = w_i_type;
          ExtSel  = w_addi;
          ALUCtrl = w_alu_ctrl;
        end
        S_WB_A: begin
          ALUSrcB   = w_i_type;
          ExtSel    = w_addi;
          ALUCtrl   = w_alu_ctrl;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          ALUM2Reg  = 1'b0;
          PCWre     = 1'b1;
          PCSrc     = 2'b00;
          RegDst    = w_r_type ? 2'b10 : 2'b01;
        end
        S_EXE_B: begin
          ALUCtrl = 3'b001;
          ExtSel  = 1'b1;
          PCWre   = 1'b1;
          PCSrc   = Zero ? 2'b01 : 2'b00;
        end
        S_EXE_M: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          ALUCtrl = 3'b000;
        end
        S_MEM: begin
          if (w_lw) begin
            RD = 1'b0;
          end else begin
            WR    = 1'b0;
            PCWre = 1'b1;
            PCSrc = 2'b00;
          end
        end
        S_WB_L: begin
          RD        = 1'b0;
          RegWre    = 1'b1;
          RegDst    = 2'b01;
          WrRegDSrc = 1'b1;
          ALUM2Reg  = 1'b1;
          PCWre     = 1'b1;
          PCSrc     = 2'b00;
        end
        default: begin
          PCWre = 1'b0;
        end
      endcase
    end
  end

endmodule
